// File: rtl/program_loader_if.sv
// Byte-stream and program-memory write bus between a byte source/controller
// (master) and the program loader (slave).
interface program_loader_if #(parameter int DATA_WIDTH = 32);
  logic                  Start_i;
  logic [7:0]            Byte_i;
  logic                  Byte_Valid_i;
  logic                  Byte_Ready_o;
  logic                  Write_Enable_o;
  logic [DATA_WIDTH-1:0] Write_Address_o;
  logic [DATA_WIDTH-1:0] Write_Data_o;
  logic                  Busy_o;
  logic                  Done_o;
  logic                  Error_o;

  modport master (
    output Start_i, Byte_i, Byte_Valid_i,
    input  Byte_Ready_o, Write_Enable_o, Write_Address_o, Write_Data_o,
           Busy_o, Done_o, Error_o
  );

  modport slave (
    input  Start_i, Byte_i, Byte_Valid_i,
    output Byte_Ready_o, Write_Enable_o, Write_Address_o, Write_Data_o,
           Busy_o, Done_o, Error_o
  );
endinterface

// File: rtl/program_loader.sv
// Assembles a length-prefixed little-endian byte stream into 32-bit words and
// writes them to program memory. PROGRAM_LOADER_CHECKSUM_EN adds a trailing XOR check byte.
module program_loader #(
  parameter int                    MEMORY_DEPTH = 32,
  parameter int                    DATA_WIDTH   = 32,
  parameter logic [DATA_WIDTH-1:0] BASE_ADDRESS = 32'h0040_0000
) (
  input logic             clk,
  input logic             reset,
  program_loader_if.slave bus
);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_WRITE, S_DONE, S_ERROR, S_CHECK} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_WRITE, S_DONE, S_ERROR} state_t;
`endif

  localparam logic [16:0] DEPTH = 17'(MEMORY_DEPTH);

  state_t                state, nxt;
  logic [15:0]           len, idx;
  logic [1:0]            bcnt;
  logic [23:0]           asm_lo;
  logic [DATA_WIDTH-1:0] addr_q, data_q;
  logic                  xfer, start_ok, last_word;
  logic [15:0]           len_full;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [7:0]            xsum;
`endif

  assign xfer      = bus.Byte_Valid_i && bus.Byte_Ready_o;
  assign start_ok  = bus.Start_i && (state inside {S_IDLE, S_DONE, S_ERROR});
  assign len_full  = {bus.Byte_i, len[7:0]};
  assign last_word = (idx + 16'd1 == len);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  assign bus.Byte_Ready_o = state inside {S_LEN_LO, S_LEN_HI, S_DATA, S_CHECK};
  assign bus.Busy_o       = state inside {S_LEN_LO, S_LEN_HI, S_DATA, S_WRITE, S_CHECK};
`else
  assign bus.Byte_Ready_o = state inside {S_LEN_LO, S_LEN_HI, S_DATA};
  assign bus.Busy_o       = state inside {S_LEN_LO, S_LEN_HI, S_DATA, S_WRITE};
`endif
  assign bus.Write_Enable_o  = (state == S_WRITE);
  assign bus.Done_o          = (state == S_DONE);
  assign bus.Error_o         = (state == S_ERROR);
  assign bus.Write_Address_o = addr_q;
  assign bus.Write_Data_o    = data_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE, S_DONE, S_ERROR: if (start_ok) nxt = S_LEN_LO;
      S_LEN_LO: if (xfer) nxt = S_LEN_HI;
      S_LEN_HI: if (xfer)
        nxt = (len_full == 16'd0 || {1'b0, len_full} > DEPTH) ? S_ERROR : S_DATA;
      S_DATA:   if (xfer && bcnt == 2'd3) nxt = S_WRITE;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      S_WRITE:  nxt = last_word ? S_CHECK : S_DATA;
      S_CHECK:  if (xfer) nxt = (bus.Byte_i == xsum) ? S_DONE : S_ERROR;
`else
      S_WRITE:  nxt = last_word ? S_DONE : S_DATA;
`endif
      default:  nxt = S_IDLE;
    endcase
  end

  // Address/data are captured with the 4th byte so they are stable throughout WRITE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      len    <= '0;
      idx    <= '0;
      bcnt   <= '0;
      asm_lo <= '0;
      addr_q <= '0;
      data_q <= '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      xsum   <= '0;
`endif
    end else begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      if (start_ok) xsum <= '0;
      if (state == S_DATA && xfer) xsum <= xsum ^ bus.Byte_i;
`endif
      if (xfer) begin
        case (state)
          S_LEN_LO: len[7:0] <= bus.Byte_i;
          S_LEN_HI: begin
            len[15:8] <= bus.Byte_i;
            idx       <= '0;
            bcnt      <= '0;
          end
          S_DATA: begin
            bcnt <= bcnt + 2'd1;
            case (bcnt)
              2'd0: asm_lo[7:0]   <= bus.Byte_i;
              2'd1: asm_lo[15:8]  <= bus.Byte_i;
              2'd2: asm_lo[23:16] <= bus.Byte_i;
              default: begin
                addr_q <= BASE_ADDRESS + DATA_WIDTH'({idx, 2'b00});
                data_q <= DATA_WIDTH'({bus.Byte_i, asm_lo});
              end
            endcase
          end
          default: ;
        endcase
      end
      if (state == S_WRITE) idx <= idx + 16'd1;
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Randomized scoreboard bench for program_loader: a driver pushes expected
// writes/status from a word-list model, a monitor pops and checks every strobe.
module tb_program_loader;
  localparam int          DW    = 32;
  localparam int          DEPTH = 32;
  localparam logic [31:0] BASE  = 32'h0040_0000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  program_loader_if #(.DATA_WIDTH(DW)) bif();

  program_loader #(.MEMORY_DEPTH(DEPTH), .DATA_WIDTH(DW), .BASE_ADDRESS(BASE)) dut (
    .clk  (clk),
    .reset(rst_n),
    .bus  (bif.slave)
  );

  int          checks = 0;
  int          fails  = 0;
  logic [63:0] exp_q[$];
  logic        prev_we = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every strobe must match the next queued write.
  always @(negedge clk) begin
    if (bif.Write_Enable_o === 1'b1) begin
      logic [63:0] e;
      chk("strobe_single_cycle", 64'(prev_we), 64'd0);
      chk("ready_low_at_strobe", 64'(bif.Byte_Ready_o), 64'd0);
      if (exp_q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_write: addr %0h data %0h at %0t",
                 bif.Write_Address_o, bif.Write_Data_o, $time);
      end else begin
        e = exp_q.pop_front();
        chk("write_addr", 64'(bif.Write_Address_o), 64'(e[63:32]));
        chk("write_data", 64'(bif.Write_Data_o), 64'(e[31:0]));
      end
    end
    prev_we <= bif.Write_Enable_o;
  end

  task automatic send_byte(input logic [7:0] b, input int maxgap);
    int t = 0;
    repeat ($urandom_range(maxgap, 0)) @(negedge clk);
    bif.Byte_i       = b;
    bif.Byte_Valid_i = 1'b1;
    while (bif.Byte_Ready_o !== 1'b1 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) begin
      checks++;
      fails++;
      $display("FAIL byte_accept_timeout: ready stayed low, byte %0h", b);
    end else begin
      @(posedge clk);
      @(negedge clk);
    end
    bif.Byte_Valid_i = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    bif.Start_i = 1'b1;
    @(negedge clk);
    bif.Start_i = 1'b0;
  endtask

  // Model: word k lands at BASE+4k; out-of-range length aborts with no write.
  task automatic run_load(input int n_field, input logic [31:0] words[$], input int maxgap,
                          input bit bad_ck, input bit poke_start);
    bit         ok = (n_field >= 1 && n_field <= DEPTH);
    logic [7:0] x  = 8'h00;
    bit         exp_done;
    if (ok) for (int k = 0; k < n_field; k++) exp_q.push_back({BASE + 32'(4 * k), words[k]});
    pulse_start();
    send_byte(8'(n_field), maxgap);
    send_byte(8'(n_field >> 8), maxgap);
    if (ok) begin
      for (int k = 0; k < n_field; k++)
        for (int j = 0; j < 4; j++) begin
          logic [7:0] b = words[k][8*j +: 8];
          x ^= b;
          send_byte(b, maxgap);
          if (poke_start && k == 0 && j == 0) pulse_start();
        end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      send_byte(bad_ck ? (x ^ 8'h01) : x, maxgap);
`endif
    end
    exp_done = ok;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    exp_done = ok && !bad_ck;
`endif
    repeat (4) @(negedge clk);
    chk("done",  64'(bif.Done_o),  64'(exp_done));
    chk("error", 64'(bif.Error_o), 64'(!exp_done));
    chk("busy_after_load", 64'(bif.Busy_o), 64'd0);
    chk("writes_outstanding", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ready"}, 64'(bif.Byte_Ready_o), 64'd0);
    chk({tag, "_we"},    64'(bif.Write_Enable_o), 64'd0);
    chk({tag, "_addr"},  64'(bif.Write_Address_o), 64'd0);
    chk({tag, "_data"},  64'(bif.Write_Data_o), 64'd0);
    chk({tag, "_busy"},  64'(bif.Busy_o), 64'd0);
    chk({tag, "_done"},  64'(bif.Done_o), 64'd0);
    chk({tag, "_error"}, 64'(bif.Error_o), 64'd0);
  endtask

  initial begin
    logic [31:0] w[$];
    bif.Start_i = 1'b0;
    bif.Byte_i = 8'h00;
    bif.Byte_Valid_i = 1'b0;
    #3 chk_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Directed basic load
    w = {32'h00A0_0513, 32'h00B0_0593};
    run_load(2, w, 0, 1'b0, 1'b0);

    // Random words with random valid gaps
    for (int r = 0; r < 4; r++) begin
      int n = $urandom_range(8, 1);
      w.delete();
      for (int k = 0; k < n; k++) w.push_back($urandom);
      run_load(n, w, 3, 1'b0, 1'b0);
    end

    // Length errors, then recovery
    w.delete();
    run_load(0, w, 1, 1'b0, 1'b0);
    run_load(33, w, 1, 1'b0, 1'b0);
    run_load(256, w, 0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) w.push_back($urandom);
    run_load(3, w, 2, 1'b0, 1'b0);

    // Full depth boundary
    w.delete();
    for (int k = 0; k < DEPTH; k++) w.push_back($urandom);
    run_load(DEPTH, w, 0, 1'b0, 1'b0);

    // Start pulsed mid-DATA is ignored
    w.delete();
    for (int k = 0; k < 2; k++) w.push_back($urandom);
    run_load(2, w, 1, 1'b0, 1'b0);
    run_load(2, w, 0, 1'b0, 1'b1);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    w = {32'h00A0_0513};
    run_load(1, w, 0, 1'b0, 1'b0);
    run_load(1, w, 0, 1'b1, 1'b0);
`endif

    // Asynchronous reset mid-DATA after two bytes
    pulse_start();
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_byte(8'h13, 0);
    send_byte(8'h05, 0);
    #2 rst_n = 1'b0;
    #1 chk_all_zero("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("post_reset_ready", 64'(bif.Byte_Ready_o), 64'd0);
    chk("post_reset_busy",  64'(bif.Busy_o), 64'd0);

    // Reload after reset still starts from the base address
    w = {32'hDEAD_BEEF};
    run_load(1, w, 1, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
